// File: rtl/exit_gate_controller_if.sv
// Exit gate request/sensor inputs and barrier/occupancy outputs.
// The controller uses the slave modport; the request/sensor side uses master.
interface exit_gate_controller_if;
  logic       exit_req;
  logic       car_passed;
  logic [7:0] parking_capacity;
  logic       gate_open;
  logic       capacity_inc;
  logic       exit_denied;
  logic       exit_timeout;
  logic       busy;

  modport master (
    output exit_req,
    output car_passed,
    output parking_capacity,
    input  gate_open,
    input  capacity_inc,
    input  exit_denied,
    input  exit_timeout,
    input  busy
  );

  modport slave (
    input  exit_req,
    input  car_passed,
    input  parking_capacity,
    output gate_open,
    output capacity_inc,
    output exit_denied,
    output exit_timeout,
    output busy
  );
endinterface

// File: rtl/exit_gate_controller.sv
// Exit barrier controller: serves one exit request per assertion, opens the gate,
// and reports a released space, a denial (lot empty) or a sensor timeout.
module exit_gate_controller #(
  parameter logic [7:0]  TOTAL_SPACES = 8'd200,
  parameter int unsigned OPEN_CYCLES  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  exit_gate_controller_if.slave bus
);

  localparam int unsigned TIMER_W = $clog2(OPEN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 gate_open_q, gate_open_d;
  logic                 capacity_inc_q, capacity_inc_d;
  logic                 exit_denied_q, exit_denied_d;
  logic                 exit_timeout_q, exit_timeout_d;
  logic                 busy_q, busy_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      gate_open_q    <= 1'b0;
      capacity_inc_q <= 1'b0;
      exit_denied_q  <= 1'b0;
      exit_timeout_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      gate_open_q    <= gate_open_d;
      capacity_inc_q <= capacity_inc_d;
      exit_denied_q  <= exit_denied_d;
      exit_timeout_q <= exit_timeout_d;
      busy_q         <= busy_d;
    end
  end

  // Capacity is only looked at on the request cycle; the sensor only matters while open.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    capacity_inc_d = 1'b0;
    exit_denied_d  = 1'b0;
    exit_timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.exit_req) begin
          if (bus.parking_capacity < TOTAL_SPACES) begin
            state_d = OPEN;
            timer_d = TIMER_W'(OPEN_CYCLES - 1);
          end else begin
            state_d       = HOLD;
            exit_denied_d = 1'b1;
          end
        end
      end
      OPEN: begin
        if (bus.car_passed) begin
          state_d        = HOLD;
          timer_d        = '0;
          capacity_inc_d = 1'b1;
        end else if (timer_q == '0) begin
          state_d        = HOLD;
          exit_timeout_d = 1'b1;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      HOLD: begin
        if (!bus.exit_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    gate_open_d = (state_d == OPEN);
    busy_d      = (state_d != IDLE);
  end

  assign bus.gate_open    = gate_open_q;
  assign bus.capacity_inc = capacity_inc_q;
  assign bus.exit_denied  = exit_denied_q;
  assign bus.exit_timeout = exit_timeout_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_exit_gate_controller.sv
// Randomized bench for exit_gate_controller against a per-request outcome model.
module tb_exit_gate_controller;

  localparam int unsigned OPEN  = 4;
  localparam logic [7:0]  TOTAL = 8'd200;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  exit_gate_controller_if bus ();

  exit_gate_controller #(
    .TOTAL_SPACES (TOTAL),
    .OPEN_CYCLES  (OPEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {gate_open, capacity_inc, exit_denied, exit_timeout, busy}
  function automatic logic [4:0] outs();
    return {bus.gate_open, bus.capacity_inc, bus.exit_denied, bus.exit_timeout, bus.busy};
  endfunction

  // Full request: model decides outcome from capacity and the sensor pattern seen
  // on each open cycle, then the output trace is compared cycle by cycle.
  task automatic txn(input logic [7:0] cap, input logic [3:0] cp, input int hold,
                     input string name);
    int         n_open;
    int         outcome;  // 0 released, 1 timed out, 2 denied
    logic [4:0] exp_v;
    logic [4:0] got;
    if (cap >= TOTAL) begin
      n_open  = 0;
      outcome = 2;
    end else begin
      n_open  = OPEN;
      outcome = 1;
      for (int k = OPEN - 1; k >= 0; k--) begin
        if (cp[k]) begin
          n_open  = k + 1;
          outcome = 0;
        end
      end
    end
    bus.exit_req         = 1'b1;
    bus.parking_capacity = cap;
    bus.car_passed       = 1'b0;
    for (int c = 0; c <= n_open + hold; c++) begin
      @(negedge clk);
      exp_v = {c < n_open,
               (c == n_open) && (outcome == 0),
               (c == n_open) && (outcome == 2),
               (c == n_open) && (outcome == 1),
               1'b1};
      got = outs();
      n_checks++;
      if (got !== exp_v)
        $display("FAIL %s cyc%0d cap=%0d cp=%b: got %b expected %b", name, c, cap, cp, got, exp_v);
      else
        n_pass++;
      bus.car_passed       = (c < n_open) ? cp[2'(c)] : 1'($urandom % 2);
      bus.parking_capacity = 8'($urandom);
    end
    bus.exit_req   = 1'b0;
    bus.car_passed = 1'b0;
    @(negedge clk);
    got = outs();
    n_checks++;
    if (got !== 5'b0)
      $display("FAIL %s release: got %b expected 00000", name, got);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    bus.exit_req         = 1'b1;
    bus.car_passed       = 1'b1;
    bus.parking_capacity = 8'd10;
    repeat (3) @(negedge clk);
    got = outs();
    n_checks++;
    if (got !== 5'b0) $display("FAIL reset_state: got %b expected 00000", got);
    else n_pass++;
    bus.exit_req   = 1'b0;
    bus.car_passed = 1'b0;
    reset          = 1'b0;
    @(negedge clk);
    got = outs();
    n_checks++;
    if (got !== 5'b0) $display("FAIL reset_idle: got %b expected 00000", got);
    else n_pass++;
  endtask

  task automatic test_stray_sensor();
    logic [4:0] got;
    bus.exit_req   = 1'b0;
    bus.car_passed = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.parking_capacity = 8'($urandom);
      @(negedge clk);
      got = outs();
      n_checks++;
      if (got !== 5'b0) $display("FAIL stray_sensor cyc%0d: got %b expected 00000", i, got);
      else n_pass++;
    end
    bus.car_passed = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [4:0] got;
    bus.exit_req         = 1'b1;
    bus.parking_capacity = 8'd120;
    bus.car_passed       = 1'b0;
    repeat (2) @(negedge clk);
    got = outs();
    n_checks++;
    if (got !== 5'b10001) $display("FAIL mid_open_pre: got %b expected 10001", got);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    got = outs();
    n_checks++;
    if (got !== 5'b0) $display("FAIL async_reset: got %b expected 00000", got);
    else n_pass++;
    bus.parking_capacity = 8'd50;
    bus.car_passed       = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = outs();
      n_checks++;
      if (got !== 5'b0) $display("FAIL in_reset cyc%0d: got %b expected 00000", i, got);
      else n_pass++;
    end
    reset          = 1'b0;
    bus.car_passed = 1'b0;
    @(negedge clk);
    got = outs();
    n_checks++;
    if (got !== 5'b10001) $display("FAIL post_reset_open: got %b expected 10001", got);
    else n_pass++;
    bus.car_passed = 1'b1;
    @(negedge clk);
    got = outs();
    n_checks++;
    if (got !== 5'b01001) $display("FAIL post_reset_inc: got %b expected 01001", got);
    else n_pass++;
    bus.exit_req   = 1'b0;
    bus.car_passed = 1'b0;
    @(negedge clk);
    got = outs();
    n_checks++;
    if (got !== 5'b0) $display("FAIL post_reset_release: got %b expected 00000", got);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    txn(8'd30,  4'b0001, 0, "b2b_a");
    txn(8'd200, 4'b0000, 0, "b2b_b");
    txn(8'd31,  4'b0000, 0, "b2b_c");
  endtask

  task automatic test_random();
    logic [7:0] cap;
    logic [3:0] cp;
    for (int i = 0; i < 40; i++) begin
      cap = ($urandom % 4 == 0) ? 8'($urandom_range(195, 255)) : 8'($urandom_range(0, 199));
      cp  = ($urandom % 3 == 0) ? 4'b0 : 4'($urandom);
      txn(cap, cp, int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                = 1'b1;
    bus.exit_req         = 1'b0;
    bus.car_passed       = 1'b0;
    bus.parking_capacity = 8'd0;
    @(negedge clk);
    test_reset();
    txn(8'd136, 4'b0010, 1,  "normal_exit");
    txn(8'd200, 4'b1111, 10, "empty_lot");
    txn(8'd0,   4'b0000, 2,  "timeout");
    txn(8'd77,  4'b1000, 0,  "simultaneous");
    txn(8'd199, 4'b0000, 0,  "cap_199");
    txn(8'd255, 4'b0101, 1,  "cap_255");
    test_reset_mid();
    test_stray_sensor();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
